// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter/sequencer for two requesters sharing an 8 x 16 register file
// Optional RFARB_ADDR_CHECK_EN: addresses >= NUM_REGS are blocked and flagged on a_err/b_err.
module regfile_arbiter #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_err,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_err,
   output logic [DATA_W-1:0] rf_wrdata,
   output logic [ADDR_W-1:0] rf_address,
   output logic              rf_wren,
   output logic              rf_rden,
   input  logic [DATA_W-1:0] rf_rddata
);

   logic              a_elig, b_elig, pick_b, win, rr_b;
   logic              win_we, win_oor;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   // Read tag stages: valid, owner (1 = B), force-zero data for rejected reads
   logic              t1_v, t1_b, t1_z, t2_v, t2_b, t2_z;

   always_comb begin
      // A request whose grant is showing this cycle is the same command still held
      a_elig    = a_req & ~a_gnt;
      b_elig    = b_req & ~b_gnt;
      pick_b    = b_elig & (~a_elig | rr_b);
      win       = a_elig | b_elig;
      win_we    = pick_b ? b_we    : a_we;
      win_addr  = pick_b ? b_addr  : a_addr;
      win_wdata = pick_b ? b_wdata : a_wdata;
`ifdef RFARB_ADDR_CHECK_EN
      win_oor   = int'(win_addr) >= NUM_REGS;
`else
      win_oor   = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_gnt      <= 1'b0;
         b_gnt      <= 1'b0;
         a_err      <= 1'b0;
         b_err      <= 1'b0;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
         rf_wrdata  <= '0;
         rf_address <= '0;
         rf_wren    <= 1'b0;
         rf_rden    <= 1'b0;
         rr_b       <= 1'b0;
         t1_v       <= 1'b0;
         t1_b       <= 1'b0;
         t1_z       <= 1'b0;
         t2_v       <= 1'b0;
         t2_b       <= 1'b0;
         t2_z       <= 1'b0;
      end else begin
         a_gnt   <= win & ~pick_b;
         b_gnt   <= win & pick_b;
         a_err   <= win & ~pick_b & win_oor;
         b_err   <= win & pick_b & win_oor;
         rf_wren <= win & win_we & ~win_oor;
         rf_rden <= win & ~win_we & ~win_oor;
         if (win) begin
            rf_address <= win_addr;
            rf_wrdata  <= win_wdata;
            rr_b       <= ~pick_b;
         end
         t1_v <= win & ~win_we;
         t1_b <= pick_b;
         t1_z <= win_oor;
         t2_v <= t1_v;
         t2_b <= t1_b;
         t2_z <= t1_z;
         a_rvalid <= t2_v & ~t2_b;
         b_rvalid <= t2_v & t2_b;
         if (t2_v & ~t2_b)
            a_rdata <= t2_z ? '0 : rf_rddata;
         if (t2_v & t2_b)
            b_rdata <= t2_z ? '0 : rf_rddata;
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized bench for regfile_arbiter against a queue-based reference model
module tb_regfile_arbiter;
`ifdef RFARB_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [3:0]  a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [15:0] a_rdata, b_rdata, rf_wrdata, rf_rddata;
   logic [3:0]  rf_address;
   logic        rf_wren, rf_rden;

   int n_chk = 0;
   int n_pass = 0;

   regfile_arbiter dut (
      .CLK(CLK), .RST(RST),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .rf_wrdata(rf_wrdata), .rf_address(rf_address), .rf_wren(rf_wren),
      .rf_rden(rf_rden), .rf_rddata(rf_rddata)
   );

   always #5 CLK = ~CLK;

   // Register file: 16 entries so unchecked out-of-range addresses still have storage
   logic [15:0] rf_mem [16];
   initial begin
      for (int i = 0; i < 16; i++) rf_mem[i] = '0;
      rf_rddata = '0;
   end
   always @(posedge CLK) begin
      if (rf_wren) rf_mem[rf_address] <= rf_wrdata;
      if (rf_rden) rf_rddata <= rf_mem[rf_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: expected outputs for the current cycle
   typedef struct { int owner; logic [15:0] data; int due; } ret_t;
   ret_t        pend[$];
   logic [15:0] m_mem [16];
   int          cyc = 0;
   int          pref = 0;
   bit          e_gnt [2], e_err [2], e_rv [2];
   logic [15:0] e_rd [2];
   bit          e_wren = 0, e_rden = 0;
   logic [3:0]  e_addr = '0;
   logic [15:0] e_wdata = '0;

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      for (int i = 0; i < 2; i++) begin
         e_gnt[i] = 0; e_err[i] = 0; e_rv[i] = 0; e_rd[i] = '0;
      end
   end

   always @(negedge CLK) begin
      bit          req [2], we [2], elig [2], ok;
      logic [3:0]  ad [2];
      logic [15:0] wd [2];
      int          w;
      check("a_gnt", a_gnt, e_gnt[0]);
      check("b_gnt", b_gnt, e_gnt[1]);
      check("a_err", a_err, e_err[0]);
      check("b_err", b_err, e_err[1]);
      check("rf_wren", rf_wren, e_wren);
      check("rf_rden", rf_rden, e_rden);
      if (e_wren || e_rden) check("rf_address", rf_address, e_addr);
      if (e_wren) check("rf_wrdata", rf_wrdata, e_wdata);
      check("a_rvalid", a_rvalid, e_rv[0]);
      check("b_rvalid", b_rvalid, e_rv[1]);
      check("a_rdata", a_rdata, e_rd[0]);
      check("b_rdata", b_rdata, e_rd[1]);

      req[0] = a_req; we[0] = a_we; ad[0] = a_addr; wd[0] = a_wdata;
      req[1] = b_req; we[1] = b_we; ad[1] = b_addr; wd[1] = b_wdata;
      if (RST) begin
         pend.delete();
         pref = 0;
         for (int i = 0; i < 2; i++) begin
            e_gnt[i] = 0; e_err[i] = 0; e_rv[i] = 0; e_rd[i] = '0;
         end
         e_wren = 0; e_rden = 0; e_addr = '0; e_wdata = '0;
      end else begin
         for (int i = 0; i < 2; i++) elig[i] = req[i] && !e_gnt[i];
         if (elig[0] && elig[1]) w = pref;
         else if (elig[0]) w = 0;
         else if (elig[1]) w = 1;
         else w = -1;
         for (int i = 0; i < 2; i++) begin
            e_gnt[i] = (w == i);
            e_err[i] = 0;
            e_rv[i]  = 0;
         end
         e_wren = 0; e_rden = 0;
         if (w >= 0) begin
            pref = 1 - w;
            ok = !(CHK && ad[w] >= 4'd8);
            e_err[w] = !ok;
            e_addr   = ad[w];
            e_wdata  = wd[w];
            e_wren   = we[w] && ok;
            e_rden   = !we[w] && ok;
            if (we[w] && ok) m_mem[ad[w]] = wd[w];
            if (!we[w]) pend.push_back('{w, ok ? m_mem[ad[w]] : 16'h0, cyc + 3});
         end
         while (pend.size() > 0 && pend[0].due == cyc + 1) begin
            e_rv[pend[0].owner] = 1;
            e_rd[pend[0].owner] = pend[0].data;
            void'(pend.pop_front());
         end
      end
      cyc++;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic cmd(input int who, input bit w_e, input logic [3:0] ad, input logic [15:0] wd);
      if (who == 0) begin a_req = 1; a_we = w_e; a_addr = ad; a_wdata = wd; end
      else          begin b_req = 1; b_we = w_e; b_addr = ad; b_wdata = wd; end
   endtask

   task automatic wait_gnt(input int who);
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         got = (who == 0) ? a_gnt : b_gnt;
      end
      check(who == 0 ? "gnt_timeout_a" : "gnt_timeout_b", got, 1);
      if (who == 0) a_req = 0; else b_req = 0;
   endtask

   initial begin
      int na, nb;
      cmd(0, 1, 4'd3, 16'hBEEF);
      cmd(1, 0, 4'd2, 16'h0);
      repeat (2) tick();
      check("rst_no_a_gnt", a_gnt, 0);
      check("rst_no_b_gnt", b_gnt, 0);
      check("rst_wren", rf_wren, 0);
      RST = 0;
      tick();
      check("first_gnt_a", a_gnt, 1);
      check("first_wren", rf_wren, 1);
      check("first_addr", rf_address, 4'd3);
      a_req = 0;
      wait_gnt(1);

      cmd(0, 0, 4'd3, 16'h0);
      wait_gnt(0);
      check("rd_rden", rf_rden, 1);
      tick();
      check("rd_early", a_rvalid, 0);
      tick();
      check("rd_rvalid", a_rvalid, 1);
      check("rd_beef", a_rdata, 16'hBEEF);

      cmd(0, 1, 4'd1, 16'h1111); wait_gnt(0);
      cmd(1, 1, 4'd2, 16'h2222); wait_gnt(1);
      cmd(0, 0, 4'd1, 16'h0);
      cmd(1, 0, 4'd2, 16'h0);
      na = 0; nb = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("alt_one_gnt", a_gnt ^ b_gnt, 1);
         check("alt_excl", rf_wren & rf_rden, 0);
         if (k >= 3) check("alt_one_rvalid", a_rvalid ^ b_rvalid, 1);
         if (a_rvalid) begin na++; check("alt_a_data", a_rdata, 16'h1111); end
         if (b_rvalid) begin nb++; check("alt_b_data", b_rdata, 16'h2222); end
      end
      a_req = 0; b_req = 0;
      check("alt_counts", (na >= 3) && (nb >= 3), 1);
      repeat (3) tick();

      cmd(1, 0, 4'd5, 16'h0);
      wait_gnt(1);
      RST = 1;
      tick();
      check("midrst_gnt", b_gnt, 0);
      check("midrst_rden", rf_rden, 0);
      RST = 0;
      tick();
      check("midrst_rv1", b_rvalid, 0);
      tick();
      check("midrst_rv2", b_rvalid, 0);

`ifdef RFARB_ADDR_CHECK_EN
      cmd(0, 1, 4'd9, 16'h5A5A);
      wait_gnt(0);
      check("oor_err", a_err, 1);
      check("oor_wren", rf_wren, 0);
      cmd(0, 0, 4'd12, 16'h0);
      wait_gnt(0);
      check("oor_rd_err", a_err, 1);
      check("oor_rd_rden", rf_rden, 0);
      repeat (2) tick();
      check("oor_rvalid", a_rvalid, 1);
      check("oor_rdata", a_rdata, 16'h0);
`else
      cmd(0, 0, 4'd9, 16'h0);
      wait_gnt(0);
      check("nochk_rden", rf_rden, 1);
      check("nochk_addr", rf_address, 4'd9);
      check("nochk_err", a_err, 0);
`endif
      repeat (3) tick();

      for (int k = 0; k < 4000; k++) begin
         RST = ($urandom_range(0, 299) == 0);
         if (!a_req || a_gnt) begin
            if ($urandom_range(0, 2) != 0) cmd(0, 1'($urandom), 4'($urandom), 16'($urandom));
            else a_req = 0;
         end
         if (!b_req || b_gnt) begin
            if ($urandom_range(0, 2) != 0) cmd(1, 1'($urandom), 4'($urandom), 16'($urandom));
            else b_req = 0;
         end
         tick();
      end
      RST = 0; a_req = 0; b_req = 0;
      repeat (5) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
